// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types, default constants and the wrapping pointer
//                increment helper for the parametrised synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Behaviour of a write that arrives while the FIFO is full
    typedef enum logic {
        FIFO_REJECT    = 1'b0,
        FIFO_OVERWRITE = 1'b1
    } fifo_mode_e;

    localparam int c_DEF_DATA_W   = 8;
    localparam int c_DEF_DEPTH    = 16;
    localparam int c_DEF_AE_LEVEL = 2;

    // Pointer increment with an explicit wrap at depth-1, so non-power-of-two
    // depths never step into the unused upper addresses.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                             input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : ptr_ctr
//  Description : Wrapping address pointer, 0..DEPTH-1, advanced by en.
//  Revision    : 1.0 - initial release
// ============================================================================
module ptr_ctr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer: hold, or step with wrap at DEPTH-1
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ADDR_W'(wrap_inc(32'(ptr_q), 32'(DEPTH)));
        end
    end

    // Pointer register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Single-clock first-word-fall-through FIFO with configurable
//                width/depth, reject or overwrite-oldest full policy,
//                threshold flags and registered error/drop strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int OVERWRITE = 0,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = c_DEF_AE_LEVEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic              dropped
);

    localparam int         c_CNT_W = ADDR_W + 1;
    localparam fifo_mode_e c_MODE  = (OVERWRITE != 0) ? FIFO_OVERWRITE : FIFO_REJECT;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic               ovf_q;
    logic               unf_q;
    logic               drop_q;

    logic [ADDR_W-1:0]  w_waddr;
    logic [ADDR_W-1:0]  w_raddr;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_only_full;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_ovf;
    logic               w_unf;
    logic               w_drop;

    // Flags depend only on the count register, so they cannot glitch on inputs
    assign w_full  = (count_q == c_CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    // A lone write against a full FIFO is the only case where policy matters
    assign w_wr_only_full = wen && !ren && w_full;

    // Write goes in unless full-and-rejecting with no simultaneous read.
    // Read pops when data exists, or implicitly when an overwrite evicts the head.
    assign w_wr_acc = wen && (!w_full || ren || (c_MODE == FIFO_OVERWRITE));
    assign w_rd_acc = (ren && !w_empty) ||
                      (w_wr_only_full && (c_MODE == FIFO_OVERWRITE));

    assign w_ovf  = w_wr_only_full && (c_MODE == FIFO_REJECT);
    assign w_drop = w_wr_only_full && (c_MODE == FIFO_OVERWRITE);
    assign w_unf  = ren && w_empty;

    ptr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_wr_acc),
        .ptr    (w_waddr)
    );

    ptr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_rd_acc),
        .ptr    (w_raddr)
    );

    // Storage array: written on accepted writes, never reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[w_waddr] <= wdata;
        end
    end

    // Occupancy next-state: only a lone accepted write or read moves it
    always_comb begin
        count_d = count_q;
        if (w_wr_acc && !w_rd_acc) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    // Occupancy and one-cycle strobe registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= w_ovf;
            unf_q   <= w_unf;
            drop_q  <= w_drop;
        end
    end

    assign rdata        = mem_q[w_raddr];
    assign count        = count_q;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign dropped      = drop_q;

`ifdef FORMAL
    logic [31:0] f_diff;
    assign f_diff = (32'(w_waddr) + 32'(DEPTH) - 32'(w_raddr)) % 32'(DEPTH);

    // Structural invariants of pointers, occupancy and strobes
    always @(posedge clk) begin
        if (rst_n) begin
            assert (32'(count_q) <= 32'(DEPTH));
            assert (32'(w_waddr) < 32'(DEPTH));
            assert (32'(w_raddr) < 32'(DEPTH));
            assert (32'(count_q) % 32'(DEPTH) == f_diff);
            assert (!(ovf_q && drop_q));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Scoreboard bench for sync_fifo_param. One shared stimulus
//                stream drives three configurations (16 reject, 16 overwrite,
//                5 reject); a queue-based model predicts each response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int         count;
        bit         empty;
        bit         full;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
        bit         drp;
        bit         rd_valid;
        logic [7:0] rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata0, rdata1, rdata2;
    logic [4:0] count0, count1;
    logic [3:0] count2;
    logic       full0, empty0, af0, ae0, ovf0, unf0, drp0;
    logic       full1, empty1, af1, ae1, ovf1, unf1, drp1;
    logic       full2, empty2, af2, ae2, ovf2, unf2, drp2;

    int checks   = 0;
    int failures = 0;

    bq_t  mq0, mq1, mq2;
    exp_t eq0 [$];
    exp_t eq1 [$];
    exp_t eq2 [$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata0), .count(count0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ovf0),
        .underflow(unf0), .dropped(drp0)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata1), .count(count1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ovf1),
        .underflow(unf1), .dropped(drp1)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(5), .OVERWRITE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata2), .count(count2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .overflow(ovf2),
        .underflow(unf2), .dropped(drp2)
    );

    // Reference model: FIFO contents as a queue, outcome from the occupancy rules
    task automatic model_step(input int depth, input bit ovw, input bit rstn,
                              input bit w, input bit r, input logic [7:0] d,
                              inout bq_t q, output exp_t e);
        int         n;
        logic [7:0] tmp;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        e.drp = 1'b0;
        if (!rstn) begin
            q.delete();
        end else begin
            n = q.size();
            if (r && n == 0) e.unf = 1'b1;
            if (w && r) begin
                if (n != 0) tmp = q.pop_front();
                q.push_back(d);
            end else if (w) begin
                if (n < depth) begin
                    q.push_back(d);
                end else if (ovw) begin
                    tmp = q.pop_front();
                    q.push_back(d);
                    e.drp = 1'b1;
                end else begin
                    e.ovf = 1'b1;
                end
            end else if (r && n != 0) begin
                tmp = q.pop_front();
            end
        end
        n          = q.size();
        e.count    = n;
        e.empty    = (n == 0);
        e.full     = (n == depth);
        e.af       = (n >= depth - 2);
        e.ae       = (n <= 2);
        e.rd_valid = (n != 0);
        e.rd       = 8'h00;
        if (n != 0) e.rd = q[0];
    endtask

    // Apply one cycle of stimulus and queue the predicted post-edge state
    task automatic drive(input bit rstn, input bit w, input bit r, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst_n = rstn;
        wen   = w;
        ren   = r;
        wdata = d;
        model_step(16, 1'b0, rstn, w, r, d, mq0, e); eq0.push_back(e);
        model_step(16, 1'b1, rstn, w, r, d, mq1, e); eq1.push_back(e);
        model_step(5,  1'b0, rstn, w, r, d, mq2, e); eq2.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t actual=0x%0h expected=0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [4:0] cnt,
                       input logic fu, input logic em, input logic af, input logic ae,
                       input logic ov, input logic un, input logic dr, input logic [7:0] rd);
        chk({tag, ".count"},        32'(cnt), 32'(e.count));
        chk({tag, ".full"},         32'(fu),  32'(e.full));
        chk({tag, ".empty"},        32'(em),  32'(e.empty));
        chk({tag, ".almost_full"},  32'(af),  32'(e.af));
        chk({tag, ".almost_empty"}, 32'(ae),  32'(e.ae));
        chk({tag, ".overflow"},     32'(ov),  32'(e.ovf));
        chk({tag, ".underflow"},    32'(un),  32'(e.unf));
        chk({tag, ".dropped"},      32'(dr),  32'(e.drp));
        if (e.rd_valid) chk({tag, ".rdata"}, 32'(rd), 32'(e.rd));
    endtask

    // Monitor: outputs settle after each rising edge; pop and compare
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq0.size() > 0) begin
                e = eq0.pop_front();
                cmp("d16rej", e, count0, full0, empty0, af0, ae0, ovf0, unf0, drp0, rdata0);
            end
            if (eq1.size() > 0) begin
                e = eq1.pop_front();
                cmp("d16ovw", e, count1, full1, empty1, af1, ae1, ovf1, unf1, drp1, rdata1);
            end
            if (eq2.size() > 0) begin
                e = eq2.pop_front();
                cmp("d5rej", e, {1'b0, count2}, full2, empty2, af2, ae2, ovf2, unf2, drp2, rdata2);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not complete");
    end

    initial begin : stimulus
        int pw, pr;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill with 0x01..0x10, then a write while full, then drain past empty
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b1, 1'b0, 8'(i));
        drive(1'b1, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 1'b1, 8'h00);

        // Empty corner cases: simultaneous write/read, then lone read
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        // Interleaved write/read pairs, then simultaneous pairs, to wrap pointers
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
            drive(1'b1, 1'b0, 1'b1, 8'h00);
        end
        drive(1'b1, 1'b1, 1'b0, 8'hC0);
        drive(1'b1, 1'b1, 1'b0, 8'hC1);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b1, 8'(8'h40 + i));

        // Randomized traffic with shifting write/read bias and rare resets
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pw = 80; pr = 20; end
                1:       begin pw = 50; pr = 50; end
                2:       begin pw = 20; pr = 80; end
                default: begin pw = 90; pr = 90; end
            endcase
            for (int i = 0; i < 100; i++) begin
                drive($urandom_range(0, 99) != 0,
                      $urandom_range(0, 99) < pw,
                      $urandom_range(0, 99) < pr,
                      8'($urandom));
            end
        end

        // Reset while holding seven entries and with requests active
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 8'(8'h70 + i));
        drive(1'b0, 1'b1, 1'b1, 8'h77);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(eq0.size() + eq1.size() + eq2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 8-bit/16-entry FIFO: configurable data width and depth (including non-power-of-two), selectable full-time policy (reject or overwrite-oldest), programmable almost-full/almost-empty thresholds, and per-cycle error/drop strobes. It sits between any producer/consumer pair in one clock domain. Formal properties are carried inline under `FORMAL`.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)
- OVERWRITE, 0, 0 = reject writes when full; 1 = write when full drops the oldest entry
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wen  in  1  write request
- wdata  in  DATA_W  write data
- ren  in  1  read request (pop head)
- rdata  out  DATA_W  head entry, first-word-fall-through
- count  out  ADDR_W+1  occupied entries, 0..DEPTH
- full / empty  out  1  count==DEPTH / count==0
- almost_full / almost_empty  out  1  threshold flags
- overflow  out  1  one-cycle pulse: write rejected (OVERWRITE=0 only)
- underflow  out  1  one-cycle pulse: read rejected because empty
- dropped  out  1  one-cycle pulse: oldest entry discarded (OVERWRITE=1 only)

## Operation
- Reset (rst_n low at a clk edge): waddr=raddr=0, count=0, overflow/underflow/dropped=0; therefore empty=1, almost_empty=1, full=0, almost_full=0. Storage not reset; rdata undefined while empty. Reset mid-operation discards contents; no partial completion.
- Accepted write: mem[waddr]<=wdata, waddr advances. Accepted read: raddr advances.
- Pointers wrap DEPTH-1 → 0 (explicit compare, not modulo-2^ADDR_W).
- count: +1 on write-only, −1 on read-only, unchanged on both/neither.
- Empty, wen&ren: write accepted, read rejected, underflow=1, count→1.
- Empty, ren only: underflow=1; neither pointer moves (no pointer resync).
- Full, wen&ren: both accepted, count stays DEPTH, no strobe.
- Full, wen only, OVERWRITE=0: write ignored, overflow=1, state unchanged.
- Full, wen only, OVERWRITE=1: write accepted, raddr also advances, count stays DEPTH, dropped=1.
- Invariants: count ≤ DEPTH; waddr,raddr < DEPTH; count ≡ (waddr−raddr) mod DEPTH, with count∈{0,DEPTH} when pointers equal; overflow and dropped never both high.
- Flags are pure functions of the count register (glitch-free, no extra state).

## Timing
- Write at edge N → entry visible on rdata, empty deasserted, count updated after edge N (cycle N+1).
- Read at edge N → next entry on rdata from cycle N+1; zero-latency head (FWFT).
- Strobes registered: asserted for exactly the cycle after the offending request edge.
- Throughput: one write and one read per cycle sustained.

## Structure
- Package fifo_pkg: fifo_mode_e {FIFO_REJECT, FIFO_OVERWRITE}; function for wrapped pointer increment; default constants.
- Sub-module ptr_ctr (ADDR_W, DEPTH): en, clk, rst_n → wrapping pointer; instantiated twice.
- Storage is an inferred register array, no reset.

## Test plan
- Reset then DEPTH=16 fill with 0x01..0x10 → full=1 after 16th write, almost_full from 14th, count=16; drain → rdata 0x01..0x10 in order, empty=1.
- OVERWRITE=0, full, write 0xAA → overflow=1 one cycle, count=16, subsequent drain unchanged (0x01 first).
- OVERWRITE=1, full, write 0xAA → dropped=1, head becomes 0x02, last drained word 0xAA.
- Empty with wen&ren, wdata=0x55 → underflow=1, count=1, rdata=0x55 next cycle; empty ren only → underflow=1, pointers unchanged.
- DEPTH=5, 12 write/read pairs interleaved → pointers wrap 4→0, count matches pointer difference each cycle.
- rst_n low mid-burst at count=7 → next cycle count=0, empty=1, all strobes 0.
